// File: rtl/param_step_dec.sv
// Handshaked decrement stage: subtracts a signed STEP from each accepted word and
// buffers {result, wrap} in a 2-entry FIFO. Define PARAM_STEP_DEC_SAT_EN to saturate.
module param_step_dec #(
    parameter int unsigned WIDTH = 4,
    parameter int          STEP  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_wrap,
    output logic [1:0]       count
);

    // Wide enough that in_data - STEP never overflows for any 32-bit STEP.
    localparam int unsigned EXT_W = WIDTH + 34;
    localparam int unsigned DEPTH = 2;
    localparam logic signed [EXT_W-1:0] STEP_EXT = EXT_W'(STEP);
    localparam logic [WIDTH-1:0] DATA_MAX = '1;
    localparam logic [1:0] CNT_FULL = 2'd2;
    localparam logic [1:0] CNT_EMPTY = 2'd0;

    logic signed [EXT_W-1:0] diff_c;
    logic [WIDTH-1:0]        res_data_c;
    logic                    res_wrap_c;

    logic [WIDTH-1:0] mem_data [DEPTH];
    logic             mem_wrap [DEPTH];
    logic             wr_ptr;
    logic             rd_ptr;
    logic             push_c;
    logic             pop_c;

    // Exact signed difference; any non-zero bit above WIDTH means out of range.
    always_comb begin
        diff_c     = $signed({{(EXT_W-WIDTH){1'b0}}, in_data}) - STEP_EXT;
        res_wrap_c = |diff_c[EXT_W-1:WIDTH];
`ifdef PARAM_STEP_DEC_SAT_EN
        if (res_wrap_c) begin
            res_data_c = diff_c[EXT_W-1] ? '0 : DATA_MAX;
        end else begin
            res_data_c = diff_c[WIDTH-1:0];
        end
`else
        res_data_c = diff_c[WIDTH-1:0];
`endif
    end

    always_comb begin
        in_ready  = (count != CNT_FULL);
        out_valid = (count != CNT_EMPTY);
        push_c    = in_valid && in_ready;
        pop_c     = out_valid && out_ready;
        out_data  = out_valid ? mem_data[rd_ptr] : '0;
        out_wrap  = out_valid ? mem_wrap[rd_ptr] : 1'b0;
    end

    // Entry storage, written at the write pointer on push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_data[i] <= '0;
                mem_wrap[i] <= 1'b0;
            end
        end else if (push_c) begin
            mem_data[wr_ptr] <= res_data_c;
            mem_wrap[wr_ptr] <= res_wrap_c;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leaves count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= CNT_EMPTY;
        end else begin
            if (push_c) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop_c) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push_c, pop_c})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_param_step_dec.sv
// Bench for param_step_dec: four parameterisations checked cycle by cycle against a
// queue-based arithmetic model, plus directed cases with fixed expected values.
module tb_param_step_dec;

`ifdef PARAM_STEP_DEC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       iv   [4];
    logic [3:0] id   [4];
    logic       ordy [4];
    logic       ir   [4];
    logic       ov   [4];
    logic       ow   [4];
    logic [3:0] od   [4];
    logic [1:0] cnt  [4];

    int tests = 0;
    int fails = 0;
    int q[$];
    int got[$];

    // Instances: (4,1), (4,-1), (4,20), (1,0)
    generate
        for (genvar g = 0; g < 4; g++) begin : g_dut
            localparam int unsigned W = (g == 3) ? 1 : 4;
            localparam int S = (g == 0) ? 1 : (g == 1) ? -1 : (g == 2) ? 20 : 0;
            logic [W-1:0] od_l;
            param_step_dec #(.WIDTH(W), .STEP(S)) dut (
                .clk(clk), .rst(rst),
                .in_valid(iv[g]), .in_ready(ir[g]), .in_data(id[g][W-1:0]),
                .out_valid(ov[g]), .out_ready(ordy[g]), .out_data(od_l),
                .out_wrap(ow[g]), .count(cnt[g])
            );
            assign od[g] = 4'(od_l);
        end
    endgenerate

    function automatic int wid(int k);
        return (k == 3) ? 1 : 4;
    endfunction

    function automatic int stp(int k);
        case (k)
            0:       return 1;
            1:       return -1;
            2:       return 20;
            default: return 0;
        endcase
    endfunction

    // Expected entry encoded as data*2 + wrap.
    function automatic int model(int k, int din);
        longint m, dm, r, d;
        bit w;
        m  = longint'(1) << wid(k);
        dm = longint'(din) & (m - 1);
        r  = dm - longint'(stp(k));
        w  = (r < 0) || (r >= m);
        if (SAT && w) d = (r < 0) ? 0 : m - 1;
        else          d = ((r % m) + m) % m;
        return int'(d) * 2 + int'(w);
    endfunction

    task automatic chk(string tag, int k, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s[%0d] observed=%0d expected=%0d", tag, k, obs, exp);
        end
    endtask

    task automatic chk_state(int k);
        chk("count", k, 32'(cnt[k]), q.size());
        chk("in_ready", k, 32'(ir[k]), 32'(q.size() != 2));
        chk("out_valid", k, 32'(ov[k]), 32'(q.size() != 0));
        chk("out_data", k, 32'(od[k]), (q.size() != 0) ? q[0] >> 1 : 0);
        chk("out_wrap", k, 32'(ow[k]), (q.size() != 0) ? q[0] & 1 : 0);
    endtask

    task automatic chk_head(int k, int d, int w);
        chk("head_valid", k, 32'(ov[k]), 1);
        chk("head_data", k, 32'(od[k]), d);
        chk("head_wrap", k, 32'(ow[k]), w);
    endtask

    task automatic set(int k, int v, int d, int r);
        iv[k]   = (v != 0);
        id[k]   = 4'(d);
        ordy[k] = (r != 0);
    endtask

    // One clock: check against the model, then advance the model across the edge.
    task automatic cycle(int k);
        bit push, pop;
        int e;
        chk_state(k);
        push = iv[k] && (q.size() < 2);
        pop  = (q.size() > 0) && ordy[k];
        e    = model(k, int'(id[k]));
        if (ov[k] && ordy[k]) got.push_back(int'(od[k]));
        @(posedge clk);
        if (pop) void'(q.pop_front());
        if (push) q.push_back(e);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        q.delete();
    endtask

    task automatic chk_reset_outputs(string tag);
        for (int k = 0; k < 4; k++) begin
            chk({tag, "_in_ready"}, k, 32'(ir[k]), 1);
            chk({tag, "_out_valid"}, k, 32'(ov[k]), 0);
            chk({tag, "_out_data"}, k, 32'(od[k]), 0);
            chk({tag, "_out_wrap"}, k, 32'(ow[k]), 0);
            chk({tag, "_count"}, k, 32'(cnt[k]), 0);
        end
    endtask

    initial begin
        int vals[3];
        int idx;
        bit acc;
        vals = '{9, 8, 7};
        for (int k = 0; k < 4; k++) set(k, 0, 0, 0);

        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b0;
        q.delete();

        // STEP=1: 5, 0, 15 back to back
        set(0, 1, 5, 1);  cycle(0); chk_head(0, 4, 0);
        set(0, 1, 0, 1);  cycle(0); chk_head(0, SAT ? 0 : 15, 1);
        set(0, 1, 15, 1); cycle(0); chk_head(0, 14, 0);
        set(0, 0, 0, 1);  cycle(0);
        chk("drained", 0, 32'(ov[0]), 0);

        // STEP=-1: 14, 15
        set(1, 1, 14, 1); cycle(1); chk_head(1, 15, 0);
        set(1, 1, 15, 1); cycle(1); chk_head(1, SAT ? 15 : 0, 1);
        set(1, 0, 0, 1);  cycle(1);

        // STEP=20: 3
        set(2, 1, 3, 1); cycle(2); chk_head(2, SAT ? 0 : 15, 1);
        set(2, 0, 0, 1); cycle(2);

        // WIDTH=1, STEP=0: 0, 1
        set(3, 1, 0, 1); cycle(3); chk_head(3, 0, 0);
        set(3, 1, 1, 1); cycle(3); chk_head(3, 1, 0);
        set(3, 0, 0, 1); cycle(3);

        // Backpressure: offer 9, 8, 7 with out_ready low
        idx = 0;
        for (int c = 0; c < 5; c++) begin
            set(0, 1, vals[idx], 0);
            acc = (q.size() < 2);
            cycle(0);
            if (acc) idx++;
        end
        chk("bp_count", 0, 32'(cnt[0]), 2);
        chk("bp_in_ready", 0, 32'(ir[0]), 0);
        for (int c = 0; c < 3; c++) begin
            set(0, 1, vals[idx], 0);
            cycle(0);
            chk_head(0, 8, 0);
        end
        got.delete();
        for (int c = 0; c < 6; c++) begin
            set(0, (idx < 3) ? 1 : 0, vals[(idx < 3) ? idx : 0], 1);
            acc = (idx < 3) && (q.size() < 2);
            cycle(0);
            if (acc) idx++;
        end
        chk("bp_pop_count", 0, got.size(), 3);
        chk("bp_pop0", 0, (got.size() > 0) ? got[0] : -1, 8);
        chk("bp_pop1", 0, (got.size() > 1) ? got[1] : -1, 7);
        chk("bp_pop2", 0, (got.size() > 2) ? got[2] : -1, 6);

        // Asynchronous reset while full
        set(0, 1, 3, 0); cycle(0);
        set(0, 1, 4, 0); cycle(0);
        chk("pre_rst_count", 0, 32'(cnt[0]), 2);
        set(0, 0, 0, 0);
        #2 rst = 1'b1;
        #1 chk_reset_outputs("async_rst");
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        set(0, 1, 1, 1); cycle(0); chk_head(0, 0, 0);
        set(0, 0, 0, 1); cycle(0);

        // Randomised traffic on every instance
        for (int k = 0; k < 4; k++) begin
            do_reset();
            for (int n = 0; n < 200; n++) begin
                set(k, int'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                    int'($urandom_range(0, 3) != 0));
                cycle(k);
            end
            set(k, 0, 0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
